// File: rtl/memory_arbiter_rr.sv
// N-port arbiter in front of a single-port block memory: grants one transaction at a time
// (round-robin or fixed priority), waits out the memory latency, and pulses a per-port done.
module memory_arbiter_rr #(
    parameter int NUM_PORTS     = 4,
    parameter int ADDR_WIDTH    = 15,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_LATENCY   = 1,
    parameter int PRIORITY_MODE = 0
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             moduleEnable,
    input  logic [NUM_PORTS-1:0]             req_enable,
    input  logic [NUM_PORTS-1:0]             req_readWrite,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_address,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_data,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]  port_dataOut,
    output logic [NUM_PORTS-1:0]             done,
    output logic [$clog2(NUM_PORTS)-1:0]     grant_index,
    output logic                             busy,
    output logic                             mem_enable,
    output logic                             mem_readWrite,
    output logic [ADDR_WIDTH-1:0]            mem_address,
    output logic [DATA_WIDTH-1:0]            mem_dataIn,
    input  logic [DATA_WIDTH-1:0]            mem_dataOut
);

    localparam int GW = $clog2(NUM_PORTS);
    localparam int CW = 3;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t        state, next_state;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] winner, rr_winner, fp_winner, rr_idx, fp_idx;
    logic          rr_found;
    logic          start;
    logic [CW-1:0] wait_cnt;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = '0;
        rr_idx    = '0;
        fp_winner = '0;
        fp_idx    = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            rr_idx = GW'((int'(last_grant) + i) % NUM_PORTS);
            if (!rr_found && req_enable[rr_idx]) begin
                rr_found  = 1'b1;
                rr_winner = rr_idx;
            end
        end
        // Scan downward so the lowest requesting index is the last one written.
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            fp_idx = GW'(i);
            if (req_enable[fp_idx]) fp_winner = fp_idx;
        end
        winner = (PRIORITY_MODE == 1) ? fp_winner : rr_winner;
        start  = moduleEnable && (|req_enable);

        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ACCESS;
            ACCESS:  next_state = WAIT;
            WAIT:    if (wait_cnt == '0) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            last_grant    <= GW'(NUM_PORTS - 1);
            grant_index   <= '0;
            wait_cnt      <= '0;
            busy          <= 1'b0;
            done          <= '0;
            mem_enable    <= 1'b0;
            mem_readWrite <= 1'b0;
            mem_address   <= '0;
            mem_dataIn    <= '0;
            // NOTE: port_dataOut is a plain register bank, not a RAM, so clearing it on reset is cheap
            // and gives requesters a defined value before their first read.
            port_dataOut  <= '0;
        end else begin
            state      <= next_state;
            done       <= '0;
            mem_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        grant_index   <= winner;
                        mem_readWrite <= req_readWrite[winner];
                        mem_address   <= req_address[winner*ADDR_WIDTH +: ADDR_WIDTH];
                        mem_dataIn    <= req_data[winner*DATA_WIDTH +: DATA_WIDTH];
                        mem_enable    <= 1'b1;
                        busy          <= 1'b1;
                    end
                end
                ACCESS: wait_cnt <= CW'(MEM_LATENCY - 1);
                WAIT: begin
                    if (wait_cnt == '0) begin
                        if (!mem_readWrite)
                            port_dataOut[grant_index*DATA_WIDTH +: DATA_WIDTH] <= mem_dataOut;
                        done[grant_index] <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                DONE: begin
                    last_grant <= grant_index;
                    busy       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
